// File: rtl/phys_free_list_if.sv
// Free-list port bundle: allocate, reclaim, checkpoint and status.
// The master drives requests; the slave (free list) answers.
interface phys_free_list_if #(
    parameter int PHYS_REG_NUM  = 64,
    parameter int ALLOC_WIDTH   = 2,
    parameter int RECLAIM_WIDTH = 2,
    parameter int CKPT_NUM      = 4
);
    localparam int PW = $clog2(PHYS_REG_NUM);
    localparam int CW = (CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1;

    logic [ALLOC_WIDTH-1:0]           alloc_req;
    logic                             alloc_ready;
    logic [ALLOC_WIDTH-1:0][PW-1:0]   alloc_preg;
    logic [RECLAIM_WIDTH-1:0]         reclaim_valid;
    logic [RECLAIM_WIDTH-1:0][PW-1:0] reclaim_preg;
    logic                             ckpt_save;
    logic [CW-1:0]                    ckpt_save_id;
    logic                             ckpt_restore;
    logic [CW-1:0]                    ckpt_restore_id;
    logic [PW:0]                      free_count;
    logic                             err;

    modport master (
        output alloc_req, reclaim_valid, reclaim_preg,
        output ckpt_save, ckpt_save_id,
        output ckpt_restore, ckpt_restore_id,
        input  alloc_ready, alloc_preg, free_count, err
    );

    modport slave (
        input  alloc_req, reclaim_valid, reclaim_preg,
        input  ckpt_save, ckpt_save_id,
        input  ckpt_restore, ckpt_restore_id,
        output alloc_ready, alloc_preg, free_count, err
    );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical registers with branch checkpoints.
// Define FREE_LIST_CHECK_EN to add a free bitmap driving the sticky err.
module phys_free_list #(
    parameter int PHYS_REG_NUM  = 64,
    parameter int REG_NUM       = 32,
    parameter int ALLOC_WIDTH   = 2,
    parameter int RECLAIM_WIDTH = 2,
    parameter int CKPT_NUM      = 4
) (
    input logic               clk,
    input logic               rst,
    phys_free_list_if.slave   bus
);
    localparam int PW = $clog2(PHYS_REG_NUM);

    typedef logic [PW:0] ptr_t;

    ptr_t          head;
    ptr_t          tail;
    ptr_t          head_next;
    ptr_t          count;
    ptr_t          a_cnt;
    ptr_t          r_cnt;
    logic [PW-1:0] fl [PHYS_REG_NUM];
    ptr_t          ckpt [CKPT_NUM];
    logic [PW-1:0] r_idx [RECLAIM_WIDTH];
    logic [RECLAIM_WIDTH-1:0] r_acc;
    logic [RECLAIM_WIDTH-1:0] r_drop;

    assign count = tail - head;
    assign bus.free_count = count;
    assign bus.alloc_ready = (count >= ptr_t'(ALLOC_WIDTH))
                           && !bus.ckpt_restore;
    assign head_next = bus.alloc_ready ? head + a_cnt : head;

    always_comb begin : alloc_lanes
        ptr_t off;
        ptr_t p;
        off = '0;
        bus.alloc_preg = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            p = head + off;
            bus.alloc_preg[i] = fl[p[PW-1:0]];
            if (bus.alloc_req[i]) off = off + ptr_t'(1);
        end
        a_cnt = off;
    end

    // A lane is dropped once the list would overflow; later lanes follow.
    always_comb begin : reclaim_lanes
        ptr_t off;
        ptr_t p;
        off = '0;
        r_acc = '0;
        r_drop = '0;
        for (int i = 0; i < RECLAIM_WIDTH; i++) begin
            p = tail + off;
            r_idx[i] = p[PW-1:0];
            r_acc[i] = bus.reclaim_valid[i]
                     && ((count + off) < ptr_t'(PHYS_REG_NUM));
            r_drop[i] = bus.reclaim_valid[i] && !r_acc[i];
            if (r_acc[i]) off = off + ptr_t'(1);
        end
        r_cnt = off;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= ptr_t'(PHYS_REG_NUM - REG_NUM);
            for (int k = 0; k < PHYS_REG_NUM; k++)
                fl[k] <= (k < PHYS_REG_NUM - REG_NUM)
                       ? PW'(REG_NUM + k) : '0;
            for (int c = 0; c < CKPT_NUM; c++)
                ckpt[c] <= '0;
        end else begin
            if (bus.ckpt_restore)
                head <= ckpt[bus.ckpt_restore_id];
            else
                head <= head_next;
            for (int i = 0; i < RECLAIM_WIDTH; i++)
                if (r_acc[i]) fl[r_idx[i]] <= bus.reclaim_preg[i];
            tail <= tail + r_cnt;
            if (bus.ckpt_save && !bus.ckpt_restore)
                ckpt[bus.ckpt_save_id] <= head_next;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    localparam logic [PHYS_REG_NUM-1:0] MAP_RST =
        {PHYS_REG_NUM{1'b1}} << REG_NUM;

    logic [PHYS_REG_NUM-1:0] free_map;
    logic [PHYS_REG_NUM-1:0] map_nx;
    logic                    err_q;
    logic                    err_nx;

    // Restore hands back every entry between restored and current head.
    always_comb begin : check_map
        ptr_t base;
        ptr_t span;
        ptr_t p;
        map_nx = free_map;
        err_nx = err_q;
        base = ckpt[bus.ckpt_restore_id];
        span = head - base;
        if (bus.ckpt_restore) begin
            for (int k = 0; k < PHYS_REG_NUM; k++) begin
                p = base + ptr_t'(k);
                if (ptr_t'(k) < span) map_nx[fl[p[PW-1:0]]] = 1'b1;
            end
        end
        if (bus.alloc_ready) begin
            for (int i = 0; i < ALLOC_WIDTH; i++) begin
                if (bus.alloc_req[i]) begin
                    if (!map_nx[bus.alloc_preg[i]]) err_nx = 1'b1;
                    map_nx[bus.alloc_preg[i]] = 1'b0;
                end
            end
        end
        for (int i = 0; i < RECLAIM_WIDTH; i++) begin
            if (r_acc[i]) begin
                if (map_nx[bus.reclaim_preg[i]]) err_nx = 1'b1;
                map_nx[bus.reclaim_preg[i]] = 1'b1;
            end
            if (r_drop[i]) err_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_map <= MAP_RST;
            err_q <= 1'b0;
        end else begin
            free_map <= map_nx;
            err_q <= err_nx;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: doc/phys_free_list.md
PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 SHALL have parameter PHYS_REG_NUM, 64, physical register count, power of two.
REQ-002 SHALL have parameter REG_NUM, 32, architectural register count, less than PHYS_REG_NUM.
REQ-003 SHALL have parameter ALLOC_WIDTH, 2, allocation lanes per cycle.
REQ-004 SHALL have parameter RECLAIM_WIDTH, 2, reclaim lanes per cycle.
REQ-005 SHALL have parameter CKPT_NUM, 4, branch checkpoint slots.
REQ-006 SHALL have ports: clk  in  1  single clock; rst  in  1  asynchronous active-high reset (decided: one clock, async active-high reset).
REQ-007 SHALL have ports: alloc_req  in  ALLOC_WIDTH  per-lane allocate request; alloc_ready  out  1  all lanes grantable; alloc_preg  out  ALLOC_WIDTH x log2(PHYS_REG_NUM)  granted index per lane.
REQ-008 SHALL have ports: reclaim_valid  in  RECLAIM_WIDTH  per-lane return; reclaim_preg  in  RECLAIM_WIDTH x log2(PHYS_REG_NUM)  returned index.
REQ-009 SHALL have ports: ckpt_save  in  1; ckpt_save_id  in  log2(CKPT_NUM); ckpt_restore  in  1; ckpt_restore_id  in  log2(CKPT_NUM).
REQ-010 SHALL have ports: free_count  out  log2(PHYS_REG_NUM)+1  entries held; err  out  1  sticky integrity error.

Function
REQ-011 SHALL store free indices in a circular buffer of PHYS_REG_NUM entries with head/tail pointers one bit wider than the index (wrap bit); free_count = tail - head, range 0..PHYS_REG_NUM.
REQ-012 SHALL drive alloc_ready combinationally high iff free_count >= ALLOC_WIDTH and ckpt_restore is low; it never depends on alloc_req.
REQ-013 SHALL give lane i, when alloc_req[i] set, entry head + popcount(alloc_req[i-1:0]); alloc_preg is combinational, same cycle, valid only when alloc_ready is high.
REQ-014 SHALL advance head by popcount(alloc_req) on a clock edge only when alloc_ready is high; requests with alloc_ready low are ignored.
REQ-015 SHALL write reclaim lane i, when set, at tail + popcount(reclaim_valid[i-1:0]) and advance tail by popcount(reclaim_valid) at the edge.
REQ-016 SHALL apply allocation and reclaim in the same cycle independently; an index reclaimed in cycle N is allocatable no earlier than cycle N+1.
REQ-017 SHALL, on ckpt_save, store the post-allocation head of that cycle into slot ckpt_save_id.
REQ-018 SHALL, on ckpt_restore, load head from slot ckpt_restore_id at the edge; same-cycle allocation is suppressed, same-cycle reclaim still applies.
REQ-019 SHALL ignore ckpt_save in a cycle where ckpt_restore is high.
REQ-020 SHALL drop reclaim lanes that would make free_count exceed PHYS_REG_NUM; tail advances only for accepted lanes.
REQ-021 SHALL wrap pointers modulo 2*PHYS_REG_NUM, with buffer index taken from the low bits.

Reset
REQ-022 SHALL on rst asynchronously set head=0, tail=PHYS_REG_NUM-REG_NUM, entry k = REG_NUM+k for k < PHYS_REG_NUM-REG_NUM, all checkpoints 0, err=0.
REQ-023 SHALL after reset show free_count=PHYS_REG_NUM-REG_NUM and alloc_ready=1, and abandon any in-flight allocation, reclaim or restore.

Configuration
REQ-024 SHALL, with FREE_LIST_CHECK_EN defined, keep a PHYS_REG_NUM-bit free bitmap and set err on: reclaim of an index already free, allocation of an index not free, or dropped reclaim (REQ-020).
REQ-025 SHALL reset the bitmap to bits REG_NUM..PHYS_REG_NUM-1 set; on restore, set bits for the entries between the restored head and the old head.
REQ-026 SHALL, without FREE_LIST_CHECK_EN, contain no bitmap and tie err to 0.

Verification
REQ-027 SHALL cover: reset, then alloc_req=2'b11 -> alloc_preg={33,32}, next cycle free_count=30.
REQ-028 SHALL cover: alloc_req=2'b10 after reset -> lane1 gets 32, head advances 1.
REQ-029 SHALL cover: 16 cycles of alloc 2'b11 -> free_count=0, alloc_ready=0, further requests no effect.
REQ-030 SHALL cover: ckpt_save id 1 at head=4, three allocs, ckpt_restore id 1 with reclaim of 5 -> head=4, free_count=29, tail+1.
REQ-031 SHALL cover: tail wrap: 40 alloc/reclaim pairs -> returned indices reappear in order after index 63 wraps.
REQ-032 SHALL cover (FREE_LIST_CHECK_EN): reclaim of index 40 while it is free -> err=1 next cycle and held until rst.
